// File: rtl/piradip_axi4mmlite_regbank.sv
// AXI4-Lite register bank: NUM_REGS control (RW) / status (RO) registers with byte strobes,
// independent AW/W acceptance, SLVERR decode and per-register write pulses.
module piradip_axi4mmlite_regbank #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [ADDR_WIDTH-1:0]          s_awaddr,
    input  logic [2:0]                     s_awprot,
    input  logic                           s_awvalid,
    output logic                           s_awready,
    input  logic [DATA_WIDTH-1:0]          s_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
    input  logic                           s_wvalid,
    output logic                           s_wready,
    output logic [1:0]                     s_bresp,
    output logic                           s_bvalid,
    input  logic                           s_bready,
    input  logic [ADDR_WIDTH-1:0]          s_araddr,
    input  logic [2:0]                     s_arprot,
    input  logic                           s_arvalid,
    output logic                           s_arready,
    output logic [DATA_WIDTH-1:0]          s_rdata,
    output logic [1:0]                     s_rresp,
    output logic                           s_rvalid,
    input  logic                           s_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int AL = $clog2(NB);
    localparam int IW = ADDR_WIDTH - AL;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                  live_q;
    logic                  aw_held_q, w_held_q, bvalid_q, rvalid_q;
    logic [IW-1:0]         aw_idx_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [NB-1:0]         wstrb_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [NUM_REGS-1:0]   wr_pulse_q;

    logic                  aw_fire, w_fire, ar_fire, commit, w_ok;
    logic [IW-1:0]         w_idx, r_idx;
    logic [DATA_WIDTH-1:0] w_data, rd_mux;
    logic [NB-1:0]         w_strb;
    logic [NUM_REGS-1:0]   w_sel, r_sel;
    logic [DATA_WIDTH-1:0] rd_src [NUM_REGS];
    logic                  unused_sig;

    // live_q keeps every ready low for the first cycle after reset release
    assign s_awready = live_q && !aw_held_q && !bvalid_q;
    assign s_wready  = live_q && !w_held_q && !bvalid_q;
    assign s_arready = live_q && !rvalid_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_rvalid  = rvalid_q;
    assign s_rresp   = rresp_q;
    assign s_rdata   = rdata_q;
    assign wr_pulse  = wr_pulse_q;

    assign aw_fire = s_awvalid && s_awready;
    assign w_fire  = s_wvalid && s_wready;
    assign ar_fire = s_arvalid && s_arready;
    assign commit  = (aw_held_q || aw_fire) && (w_held_q || w_fire);

    assign w_idx  = aw_held_q ? aw_idx_q : s_awaddr[ADDR_WIDTH-1:AL];
    assign w_data = w_held_q ? wdata_q : s_wdata;
    assign w_strb = w_held_q ? wstrb_q : s_wstrb;
    assign r_idx  = s_araddr[ADDR_WIDTH-1:AL];
    // out-of-range indices select nothing, so they fall out as SLVERR naturally
    assign w_ok   = |(w_sel & ~RO_MASK);

    assign unused_sig = ^{s_awprot, s_arprot, s_awaddr[AL-1:0], s_araddr[AL-1:0], reg_in};

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_sel[i]) rd_mux = rd_src[i];
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        assign w_sel[gi] = (w_idx == IW'(gi));
        assign r_sel[gi] = (r_idx == IW'(gi));
        if (RO_MASK[gi]) begin : g_ro
            assign rd_src[gi] = reg_in[gi*DATA_WIDTH +: DATA_WIDTH];
            assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
        end else begin : g_rw
            logic [DATA_WIDTH-1:0] reg_q, reg_d;
            always_comb begin
                reg_d = reg_q;
                for (int k = 0; k < NB; k++) begin
                    if (w_strb[k]) reg_d[8*k +: 8] = w_data[8*k +: 8];
                end
            end
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) reg_q <= RESET_VALUE;
                else if (commit && w_sel[gi]) reg_q <= reg_d;
            end
            assign rd_src[gi] = reg_q;
            assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = reg_q;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            live_q     <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
        end else begin
            live_q <= 1'b1;
            if (commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
            end else begin
                if (aw_fire) begin
                    aw_held_q <= 1'b1;
                    aw_idx_q  <= s_awaddr[ADDR_WIDTH-1:AL];
                end
                if (w_fire) begin
                    w_held_q <= 1'b1;
                    wdata_q  <= s_wdata;
                    wstrb_q  <= s_wstrb;
                end
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= w_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (s_bready) begin
                bvalid_q <= 1'b0;
            end
            wr_pulse_q <= commit ? (w_sel & ~RO_MASK) : '0;
        end
    end

    // register contents are sampled before any same-edge write lands
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_fire) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_mux;
            rresp_q  <= (|r_sel) ? RESP_OKAY : RESP_SLVERR;
        end else if (s_rready) begin
            rvalid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_piradip_axi4mmlite_regbank.sv
// Self-checking bench for the AXI4-Lite register bank: directed cases then random traffic
// compared against an array-based register model.
module tb_piradip_axi4mmlite_regbank;
    localparam int              AW = 8;
    localparam int              DW = 32;
    localparam int              NR = 16;
    localparam logic [NR-1:0]   RO = 16'h0088;
    localparam logic [DW-1:0]   RV = 32'h5A5A_5A5A;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic [AW-1:0] s_awaddr = '0, s_araddr = '0;
    logic [2:0]    s_awprot = '0, s_arprot = '0;
    logic          s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
    logic [DW-1:0] s_wdata = '0;
    logic [3:0]    s_wstrb = '0;
    logic          s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]    s_bresp, s_rresp;
    logic [DW-1:0] s_rdata;
    logic [NR*DW-1:0] reg_out, reg_in;
    logic [NR-1:0]    wr_pulse;

    logic [DW-1:0] m_reg [NR];
    logic [DW-1:0] rin [NR];
    int tests = 0;
    int fails = 0;

    always #5 aclk = ~aclk;

    always_comb begin
        reg_in = '0;
        for (int i = 0; i < NR; i++) reg_in[i*DW +: DW] = rin[i];
    end

    piradip_axi4mmlite_regbank #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(RO), .RESET_VALUE(RV)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse)
    );

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic logic [NR*DW-1:0] exp_regout();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = RO[i] ? '0 : m_reg[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_reg[i] = RV;
    endtask

    task automatic exp_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        int idx;
        idx = int'(a[7:2]);
        if (idx >= NR) begin d = '0; r = 2'b10; end
        else if (RO[idx]) begin d = rin[idx]; r = 2'b00; end
        else begin d = m_reg[idx]; r = 2'b00; end
    endtask

    // Called at a negedge; drives AW/W with independent delays, then holds B for b_hold cycles.
    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_hold, output int cyc);
        int idx;
        bit ok, aw_done, w_done, aw_f, w_f;
        logic [NR-1:0] exp_pulse;
        idx = int'(a[7:2]);
        ok = 0;
        if (idx < NR) ok = !RO[idx];
        exp_pulse = ok ? (NR'(1) << idx) : '0;
        aw_done = 0; w_done = 0; cyc = 0;
        s_awaddr = a; s_wdata = d; s_wstrb = s;
        while (!(aw_done && w_done) && cyc < 40) begin
            s_awvalid = !aw_done && cyc >= aw_dly;
            s_wvalid  = !w_done && cyc >= w_dly;
            aw_f = s_awvalid && s_awready;
            w_f  = s_wvalid && s_wready;
            if (w_done && !aw_done) chk("wready_low_while_w_held", s_wready, 0);
            if (aw_done && !w_done) chk("awready_low_while_aw_held", s_awready, 0);
            @(negedge aclk);
            cyc++;
            aw_done |= aw_f;
            w_done  |= w_f;
        end
        s_awvalid = 0; s_wvalid = 0;
        chk("aw_w_accepted", aw_done && w_done, 1);
        if (ok) for (int k = 0; k < 4; k++) if (s[k]) m_reg[idx][8*k +: 8] = d[8*k +: 8];
        chk("bvalid_after_commit", s_bvalid, 1);
        chk("bresp", s_bresp, ok ? 2'b00 : 2'b10);
        chk("wr_pulse_at_bvalid", wr_pulse, exp_pulse);
        chk("reg_out_after_write", reg_out, exp_regout());
        for (int h = 0; h < b_hold; h++) begin
            @(negedge aclk);
            chk("bvalid_held", s_bvalid, 1);
            chk("bresp_held", s_bresp, ok ? 2'b00 : 2'b10);
            chk("ready_low_b_pending", {s_awready, s_wready}, 2'b00);
            chk("wr_pulse_one_cycle", wr_pulse, 0);
        end
        s_bready = 1;
        @(negedge aclk);
        s_bready = 0;
        chk("bvalid_cleared", s_bvalid, 0);
        chk("wr_pulse_cleared", wr_pulse, 0);
        chk("ready_after_b", {s_awready, s_wready}, 2'b11);
    endtask

    task automatic do_read(input logic [7:0] a, input int r_hold,
                           input logic [31:0] ed, input logic [1:0] er);
        int cyc;
        cyc = 0;
        s_araddr = a; s_arvalid = 1;
        while (!s_arready && cyc < 40) begin
            @(negedge aclk);
            cyc++;
        end
        chk("ar_accept", s_arready, 1);
        @(negedge aclk);
        s_arvalid = 0;
        chk("rvalid_next_cycle", s_rvalid, 1);
        chk("rdata", s_rdata, ed);
        chk("rresp", s_rresp, er);
        for (int h = 0; h < r_hold; h++) begin
            @(negedge aclk);
            chk("r_held", {s_rvalid, s_rresp, s_rdata}, {1'b1, er, ed});
            chk("arready_low_r_pending", s_arready, 0);
        end
        s_rready = 1;
        @(negedge aclk);
        s_rready = 0;
        chk("rvalid_cleared", s_rvalid, 0);
        chk("arready_after_r", s_arready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [31:0] ed, old1;
        logic [1:0]  er;
        logic [7:0]  a;
        for (int i = 0; i < NR; i++) rin[i] = $urandom;
        rin[3] = 32'h1234_5678;
        model_reset();

        repeat (3) @(negedge aclk);
        chk("rst_readies", {s_awready, s_wready, s_arready}, 3'b000);
        chk("rst_valids", {s_bvalid, s_rvalid}, 2'b00);
        chk("rst_resps", {s_bresp, s_rresp}, 4'b0000);
        chk("rst_rdata", s_rdata, 0);
        chk("rst_wr_pulse", wr_pulse, 0);
        chk("rst_reg_out", reg_out, exp_regout());
        aresetn = 1;
        #1 chk("ready_low_at_release", {s_awready, s_wready, s_arready}, 3'b000);
        @(negedge aclk);
        chk("ready_high_after_release", {s_awready, s_wready, s_arready}, 3'b111);

        // AW+W together: one-cycle latency
        do_write(8'h04, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, cyc);
        chk("same_cycle_latency", cyc, 1);
        chk("reg1_deadbeef", reg_out[1*DW +: DW], 32'hDEAD_BEEF);

        // W three cycles ahead of AW, low byte only
        do_write(8'h08, 32'h0000_00AA, 4'b0001, 3, 0, 0, cyc);
        chk("reg2_low_byte", reg_out[2*DW +: DW], 32'h5A5A_5AAA);

        // AW ahead of W, strobe 0 still pulses
        do_write(8'h18, 32'hFFFF_FFFF, 4'b0000, 0, 2, 0, cyc);
        chk("reg6_strb0_unchanged", reg_out[6*DW +: DW], RV);

        // read-only register
        do_read(8'h0C, 0, 32'h1234_5678, 2'b00);
        do_write(8'h0C, 32'hCAFE_F00D, 4'hF, 0, 0, 0, cyc);

        // out of range
        do_write(8'h40, 32'h0BAD_0BAD, 4'hF, 1, 0, 0, cyc);
        do_read(8'h40, 0, 32'h0, 2'b10);

        // back-pressure on B and R
        do_write(8'h14, 32'h1357_9BDF, 4'hF, 0, 0, 5, cyc);
        do_read(8'h14, 5, 32'h1357_9BDF, 2'b00);

        // read and write to the same register on the same edge
        old1 = m_reg[1];
        fork
            do_write(8'h04, 32'h0102_0304, 4'hF, 0, 0, 0, cyc);
            do_read(8'h04, 0, old1, 2'b00);
        join
        do_read(8'h04, 0, 32'h0102_0304, 2'b00);

        // reset while B is pending
        s_awaddr = 8'h10; s_wdata = 32'h7777_7777; s_wstrb = 4'hF;
        s_awvalid = 1; s_wvalid = 1;
        @(negedge aclk);
        s_awvalid = 0; s_wvalid = 0;
        chk("bvalid_before_reset", s_bvalid, 1);
        #2 aresetn = 0;
        model_reset();
        #1;
        chk("reset_drops_bvalid", s_bvalid, 0);
        chk("reset_readies", {s_awready, s_wready, s_arready}, 3'b000);
        chk("reset_reg_out", reg_out, exp_regout());
        @(negedge aclk);
        aresetn = 1;
        @(negedge aclk);
        do_write(8'h10, 32'h2468_ACE0, 4'hF, 0, 0, 0, cyc);
        do_read(8'h04, 0, RV, 2'b00);

        // random traffic
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < NR; i++) rin[i] = $urandom;
            a = 8'($urandom_range(0, 8'h47));
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), cyc);
            end else begin
                exp_read(a, ed, er);
                do_read(a, $urandom_range(0, 2), ed, er);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
